// File: rtl/sha256_digest_reader.sv
// Digest read-back engine: fetches NUM_WORDS words from output_addr over the SHA-256 word bus,
// streams them on valid/ready and, when built with DIGEST_CMP_EN, compares against expected_digest.
module sha256_digest_reader #(
  parameter int NUM_WORDS = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  output_addr,
  input  logic [255:0] expected_digest,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         done,
  output logic         match
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

  logic [2:0] state;
  logic [4:0] idx;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx   <= '0;
          done  <= 1'b0;
          state <= S_REQ;
        end
        S_REQ: begin
          mem_addr <= output_addr + {11'd0, idx};
          state    <= S_WAIT;
        end
        // address held here so the bus's second latency cycle completes before capture
        S_WAIT: state <= S_CAPT;
        S_CAPT: begin
          out_data  <= mem_read_data;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: if (out_ready) begin
          out_valid <= 1'b0;
          idx       <= idx + 5'd1;
          state     <= (idx == LAST_IDX) ? S_FIN : S_REQ;
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DIGEST_CMP_EN
  logic         mism;
  logic [255:0] exp_sh;
  logic [31:0]  exp_word;

  // words beyond the 256-bit digest shift in as zero
  assign exp_sh   = expected_digest << {idx, 5'd0};
  assign exp_word = exp_sh[255:224];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mism  <= 1'b0;
      match <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (start) mism <= 1'b0;
        S_CAPT:  mism  <= mism | (mem_read_data != exp_word);
        S_FIN:   match <= ~mism;
        default: ;
      endcase
    end
  end
`else
  logic unused_expected;
  assign unused_expected = ^expected_digest;
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Scoreboard bench for sha256_digest_reader: reference words/match pushed per run, monitor pops on handshake.
module tb_sha256_digest_reader;

  logic         clk = 1'b0;
  logic         reset_n, start, out_ready;
  logic [15:0]  output_addr;
  logic [255:0] expected_digest;
  logic         mem_clk, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_read_data, out_data;
  logic         out_valid, done, match;

  always #5 clk = ~clk;

  sha256_digest_reader #(.NUM_WORDS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr),
    .expected_digest(expected_digest), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .done(done), .match(match)
  );

  // bus model: data appears one registered cycle after the address, captured by the reader a cycle later
  logic [31:0] mem [0:65535];
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0;
  int ready_mode = 0, stall_word = 0, stall_n = 0, stall_seen = 0;
  int hs_cnt = 0, vcycles = 0, stall_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // ready is decided at the negedge, so a valid&&ready seen here is the handshake of the next posedge
  always @(negedge clk) begin
    logic r;
    exp_t e;
    if (reset_n && out_valid) begin
      r = 1'b1;
      if (ready_mode == 1 && hs_cnt == stall_word && stall_seen < stall_n) begin
        r = 1'b0;
        stall_seen++;
      end else if (ready_mode == 2) r = ($urandom_range(0, 2) != 0);
      out_ready = r;
      vcycles++;
      if (!r) stall_total++;
      if (r) begin
        if (sb.size() == 0) chk("unexpected word", out_data, 32'hxxxxxxxx);
        else begin
          e = sb.pop_front();
          chk("word data", out_data, e.data);
          chk("word addr", {16'd0, mem_addr}, {16'd0, e.addr});
          chk("mem_we low", {31'd0, mem_we}, 32'd0);
          if (ready_mode == 1 && hs_cnt == stall_word)
            chk("stall hold cycles", vcycles, stall_n + 1);
        end
        hs_cnt++;
        vcycles = 0;
      end
    end else out_ready = 1'b1;
  end

  task automatic run(input logic [15:0] addr, input int mode, input int sw, input int sn,
                     input bit mid_pulse, input logic [255:0] ed, input string tag);
    bit eq;
    logic em;
    int c, lat;
    logic [15:0] a;
    eq = 1;
    for (int i = 0; i < 8; i++) begin
      a = addr + 16'(i);
      sb.push_back('{addr: a, data: mem[a]});
      if (mem[a] != ed[255-32*i -: 32]) eq = 0;
    end
`ifdef DIGEST_CMP_EN
    em = eq;
`else
    em = 1'b0;
`endif
    ready_mode = mode; stall_word = sw; stall_n = sn; stall_seen = 0;
    hs_cnt = 0; vcycles = 0; stall_total = 0;
    output_addr = addr;
    expected_digest = ed;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    chk({tag, " done cleared by start"}, {31'd0, done}, 32'd0);
    c = 0;
    while (!done && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (mid_pulse) start = (c == 17);
    end
    start = 1'b0;
    lat = (mode == 2) ? 33 + stall_total : 33 + sn;
    chk({tag, " done latency"}, c, lat);
    chk({tag, " match"}, {31'd0, match}, {31'd0, em});
    chk({tag, " words streamed"}, hs_cnt, 8);
    chk({tag, " scoreboard empty"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk({tag, " done held"}, {31'd0, done}, 32'd1);
    chk({tag, " match held"}, {31'd0, match}, {31'd0, em});
  endtask

  logic [31:0]  golden [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [255:0] gd, rd_ed;
  logic [15:0]  ra;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    output_addr = '0; expected_digest = '0;
    for (int i = 0; i < 8; i++) begin
      mem[16'h0100 + i] = golden[i];
      gd[255-32*i -: 32] = golden[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset match", {31'd0, match}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    run(16'h0100, 0, 0, 0, 0, gd, "golden");
    mem[16'h0105] = 32'h96177a9d;
    run(16'h0100, 0, 0, 0, 0, gd, "mismatch");
    mem[16'h0105] = golden[5];
    run(16'h0100, 1, 3, 5, 0, gd, "stall");

    for (int i = 0; i < 8; i++) begin
      mem[16'hFFFE + 16'(i)] = $urandom;
      rd_ed[255-32*i -: 32] = mem[16'hFFFE + 16'(i)];
    end
    run(16'hFFFE, 0, 0, 0, 0, rd_ed, "wrap");

    run(16'h0100, 0, 0, 0, 1, gd, "midstart");
    run(16'h0100, 0, 0, 0, 0, gd, "rerun");

    // reset during WAIT of word 2 (state WAIT between edges 9 and 10 after start)
    ready_mode = 0; hs_cnt = 0; vcycles = 0;
    for (int i = 0; i < 8; i++) sb.push_back('{addr: 16'h0100 + 16'(i), data: golden[i]});
    output_addr = 16'h0100; expected_digest = gd;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("abort words before reset", hs_cnt, 2);
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort out_data", out_data, 32'd0);
    chk("abort mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort match", {31'd0, match}, 32'd0);
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle after reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle after reset done", {31'd0, done}, 32'd0);
    chk("idle after reset mem_addr", {16'd0, mem_addr}, 32'd0);

    for (int t = 0; t < 4; t++) begin
      int fw;
      ra = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
        mem[ra + 16'(i)] = $urandom;
        rd_ed[255-32*i -: 32] = mem[ra + 16'(i)];
      end
      if ($urandom_range(0, 1) == 1) begin
        fw = $urandom_range(0, 7);
        rd_ed[255-32*fw -: 32] = rd_ed[255-32*fw -: 32] ^ (32'd1 << $urandom_range(0, 31));
      end
      run(ra, 2, 0, 0, 0, rd_ed, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sha256_digest_reader.md
# sha256_digest_reader

Digest read-back engine that sits on the same single-port word memory bus as the SHA-256 core, on the opposite side of the transfer: the core writes the 8-word digest to `output_addr`, and this block reads those words back. On `start` it fetches `NUM_WORDS` words from `output_addr` with the bus's fixed two-cycle read latency. It presents each word on a valid/ready output stream and optionally checks the full digest against an expected value. It is used by the host/check logic to retire a hash result without touching the memory port directly.

## Interface
- `NUM_WORDS`, default 8: words fetched per request (1..16).
- `clk` input 1: single clock; also forwarded as `mem_clk`.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a read-back; sampled only in IDLE.
- `output_addr` input 16: base word address of the digest.
- `expected_digest` input 256: reference digest; word 0 = bits [255:224].
- `mem_clk` output 1: equals `clk`.
- `mem_we` output 1: always 0 (reader never writes).
- `mem_addr` output 16: read address.
- `mem_read_data` input 32: memory read data.
- `out_valid` output 1: `out_data` holds a fetched word.
- `out_ready` input 1: consumer accepts word when high with `out_valid`.
- `out_data` output 32: fetched digest word.
- `done` output 1: high from completion until next accepted `start`.
- `match` output 1: compare result, meaningful when `done`=1.

## Operation
- States: IDLE, REQ, WAIT, CAPT, SEND, FIN.
- IDLE: `start`=1 clears `idx` to 0, `done` to 0, and `mism` to 0, then goes to REQ. If `start`=0, the block stays in IDLE.
- REQ: drive `mem_addr` <= `output_addr` + `idx` (16-bit wrap, carry dropped) and `mem_we` <= 0, then go to WAIT.
- WAIT: hold the address for one cycle to cover the memory latency, then go to CAPT.
- CAPT: latch `mem_read_data` into `out_data`, set `out_valid` <= 1, and go to SEND. With compare compiled in, set `mism` <= `mism` | (word != expected word `idx`).
- SEND: hold `out_data` and `out_valid` until `out_ready`=1. On the handshake:
  - drop `out_valid`, increment `idx`;
  - if `idx` = `NUM_WORDS`-1, go to FIN; otherwise go to REQ.
- FIN: `done` <= 1 and `match` <= !`mism`, then go to IDLE.
- `start` asserted in any state other than IDLE is ignored, with no restart and no queuing.
- `output_addr` is sampled every REQ and must be held stable by the driver for the whole operation.
- Words stream in address order, `idx` 0 first.

## Timing
- Reset values:
  - state IDLE, `idx` 0, `mism` 0;
  - `mem_we` 0, `mem_addr` 0;
  - `out_valid` 0, `out_data` 0;
  - `done` 0, `match` 0.
- Reset asserted mid-operation aborts immediately to IDLE with the reset values above. A word that was presented but not accepted is dropped.
- Per word with `out_ready` held at 1: REQ, WAIT, CAPT, SEND is 4 cycles. `out_valid` rises the cycle after CAPT.
- Each `out_ready`-low cycle in SEND adds one cycle.
- Full read-back of 8 words with `out_ready`=1 takes 32 cycles after the `start` edge, then `done` rises 1 cycle after the last handshake (FIN).
- `done` and `match` are registered levels, not pulses. Both hold until the next accepted `start`, which clears `done` in the same edge.
- `out_valid` never drops without a handshake, except on reset.

## Configuration
- Macro `DIGEST_CMP_EN`.
- Defined: the `mism` accumulator and comparison against `expected_digest` are compiled in. `match` = 1 iff all `NUM_WORDS` words equal the corresponding words of `expected_digest` (word `i` = bits [255-32i -: 32]).
- Not defined: the comparison logic is absent, `expected_digest` is unused, and `match` is tied to 0. All other behaviour and timing are identical.

## Test plan
- Memory[0x0100..0x0107] = 0xba7816bf, 0x8f01cfea, 0x414140de, 0x5dae2223, 0xb00361a3, 0x96177a9c, 0xb410ff61, 0xf20015ad. `expected_digest` = the same words, `output_addr`=0x0100, `out_ready`=1, pulse `start`:
  - 8 words arrive in order;
  - `mem_we` stays 0;
  - `done`=1 at cycle 33;
  - `match`=1 with `DIGEST_CMP_EN`, 0 without.
- Same setup but memory[0x0105] = 0x96177a9d -> `done`=1 and `match`=0. All 8 words are still streamed.
- `out_ready` low for 5 cycles on word 3 -> `out_data`=0x5dae2223 is held with `out_valid`=1 for 6 cycles, and `done` is delayed by exactly 5 cycles.
- `output_addr`=0xFFFE -> `mem_addr` sequence is 0xFFFE, 0xFFFF, 0x0000 … 0x0005.
- `start` pulsed again during word 4, followed by a second `start` after `done` -> the mid-run pulse is ignored, and the second `start` clears `done` on its edge and reruns the read-back.
- `reset_n` low during WAIT of word 2 -> all outputs return to their reset values asynchronously. After release, the block idles until `start`.
